// File: rtl/gpio_apb_arb_pkg.sv
// Shared types and helpers for the GPIO APB round-robin arbiter.
package gpio_apb_arb_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [AddrWidth-1:0] paddr;
        logic [2:0]           pprot;
        logic                 psel;
        logic                 penable;
        logic                 pwrite;
        logic [DataWidth-1:0] pwdata;
        logic [StrbWidth-1:0] pstrb;
    } gpio_apb_req_t;

    typedef struct packed {
        logic                 pready;
        logic [DataWidth-1:0] prdata;
        logic                 pslverr;
    } gpio_apb_rsp_t;

    // Successor of idx in a ring of n entries.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx == n - 32'd1) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/gpio_apb_rr_pick.sv
// Round-robin picker: first set request at or after rr, wrapping at N.
module gpio_apb_rr_pick #(
    parameter int unsigned N        = 2,
    parameter int unsigned IdxWidth = $clog2(N)
) (
    input  logic [N-1:0]        req,
    input  logic [IdxWidth-1:0] rr,
    output logic                valid,
    output logic [IdxWidth-1:0] idx
);

    int unsigned cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 32'd0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(rr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!valid && req[IdxWidth'(cand)]) begin
                valid = 1'b1;
                idx   = IdxWidth'(cand);
            end
        end
    end

endmodule

// File: rtl/gpio_apb_arbiter.sv
// Round-robin arbiter sharing one GPIO APB slave port between NrMasters requesters.
module gpio_apb_arbiter
    import gpio_apb_arb_pkg::*;
#(
    parameter int unsigned NrMasters = 2,
    parameter type         apb_req_t = gpio_apb_req_t,
    parameter type         apb_rsp_t = gpio_apb_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  apb_req_t apb_req_i [NrMasters],
    output apb_rsp_t apb_rsp_o [NrMasters],
    output apb_req_t apb_req_o,
    input  apb_rsp_t apb_rsp_i
);

    localparam int unsigned IdxWidth = $clog2(NrMasters);

    arb_state_e          state_q;
    logic [IdxWidth-1:0] gnt_q;
    logic [IdxWidth-1:0] rr_q;
    logic [NrMasters-1:0] psel_vec;
    logic                pick_valid;
    logic [IdxWidth-1:0] pick_idx;
    logic                abort;

    always_comb begin
        for (int unsigned i = 0; i < NrMasters; i++) begin
            psel_vec[i] = apb_req_i[i].psel;
        end
    end

    gpio_apb_rr_pick #(
        .N        (NrMasters),
        .IdxWidth (IdxWidth)
    ) u_pick (
        .req   (psel_vec),
        .rr    (rr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Granted master withdrew psel before the slave completed.
    assign abort = (state_q != IDLE) && !apb_req_i[gnt_q].psel;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_q   <= pick_idx;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    state_q <= abort ? IDLE : ACCESS;
                end
                ACCESS: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (apb_rsp_i.pready) begin
                        rr_q    <= IdxWidth'(rr_next(32'(gnt_q), NrMasters));
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Slave request: granted master's transfer with the phase set by the arbiter.
    always_comb begin
        apb_req_o = '0;
        if (state_q != IDLE) begin
            apb_req_o         = apb_req_i[gnt_q];
            apb_req_o.penable = (state_q == ACCESS);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NrMasters; i++) begin
            apb_rsp_o[i]        = '0;
            apb_rsp_o[i].prdata = apb_rsp_i.prdata;
            if (state_q == ACCESS && gnt_q == IdxWidth'(i)) begin
                apb_rsp_o[i].pready  = apb_rsp_i.pready;
                apb_rsp_o[i].pslverr = apb_rsp_i.pslverr;
            end
        end
    end

    always @(posedge clk_i) begin
        if (rst_ni) begin
            psel_held: assert (!abort)
                else $warning("gpio_apb_arbiter: granted master dropped psel mid-transfer");
        end
    end

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Directed bench for gpio_apb_arbiter with three masters.
module tb_gpio_apb_arbiter;
    import gpio_apb_arb_pkg::*;

    logic          clk;
    logic          rst_n;
    gpio_apb_req_t mreq [3];
    gpio_apb_rsp_t mrsp [3];
    gpio_apb_req_t sreq;
    gpio_apb_rsp_t srsp;

    int checks = 0;
    int errors = 0;

    gpio_apb_arbiter #(.NrMasters(3)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .apb_req_i (mreq),
        .apb_rsp_o (mrsp),
        .apb_req_o (sreq),
        .apb_rsp_i (srsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    function automatic gpio_apb_req_t make_req(input logic [31:0] addr, input logic [31:0] data,
                                               input logic write);
        gpio_apb_req_t r;
        r         = '0;
        r.paddr   = addr;
        r.pwdata  = data;
        r.pwrite  = write;
        r.pprot   = 3'b010;
        r.pstrb   = 4'hF;
        r.psel    = 1'b1;
        return r;
    endfunction

    // Call during the IDLE cycle in which master m will be picked; ends in the following IDLE cycle.
    task automatic serve(input int m, input int nwait, input logic err, input logic [2:0] drop);
        @(negedge clk); #1;
        chk("setup_psel", 32'(sreq.psel), 32'd1);
        chk("setup_penable", 32'(sreq.penable), 32'd0);
        chk("setup_gnt", 32'(dut.gnt_q), 32'(m));
        chk("setup_paddr", sreq.paddr, mreq[m].paddr);
        for (int j = 0; j < 3; j++) chk("setup_pready", 32'(mrsp[j].pready), 32'd0);
        for (int w = 0; w <= nwait; w++) begin
            @(negedge clk);
            srsp.pready  = (w == nwait);
            srsp.pslverr = err && (w == nwait);
            srsp.prdata  = 32'hC0DE_0000 + 32'(w);
            #1;
            chk("access_penable", 32'(sreq.penable), 32'd1);
            chk("access_pwdata", sreq.pwdata, mreq[m].pwdata);
            chk("access_ctl", {24'd0, sreq.pwrite, sreq.pprot, sreq.pstrb},
                {24'd0, mreq[m].pwrite, mreq[m].pprot, mreq[m].pstrb});
            chk("prdata_bcast", mrsp[(m + 1) % 3].prdata, 32'hC0DE_0000 + 32'(w));
            for (int j = 0; j < 3; j++) begin
                chk("pready_route", 32'(mrsp[j].pready), 32'(j == m && w == nwait));
                chk("pslverr_route", 32'(mrsp[j].pslverr), 32'(j == m && w == nwait && err));
            end
        end
        @(negedge clk);
        srsp = '0;
        for (int j = 0; j < 3; j++) if (drop[j]) mreq[j].psel = 1'b0;
        #1;
        chk("done_idle", 32'(dut.state_q), 32'(IDLE));
        chk("done_psel", 32'(sreq.psel), 32'd0);
        chk("done_rr", 32'(dut.rr_q), 32'((m + 1) % 3));
    endtask

    initial begin
        rst_n = 1'b0;
        srsp  = '0;
        for (int j = 0; j < 3; j++) mreq[j] = '0;

        // Reset values
        @(negedge clk); #1;
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_rr", 32'(dut.rr_q), 32'd0);
        chk("rst_gnt", 32'(dut.gnt_q), 32'd0);
        chk("rst_req_o", 32'(sreq != '0), 32'd0);
        for (int j = 0; j < 3; j++) chk("rst_pready", 32'({mrsp[j].pready, mrsp[j].pslverr}), 32'd0);
        rst_n = 1'b1;

        // Single master 0 write, immediate pready
        @(negedge clk);
        mreq[0] = make_req(32'h0, 32'hA5A5_0000, 1'b1);
        #1;
        chk("t1_idle_psel", 32'(sreq.psel), 32'd0);
        serve(0, 0, 1'b0, 3'b001);

        // Master 2 alone: rr wraps 2 -> 0
        mreq[2] = make_req(32'h8, 32'h0000_0022, 1'b0);
        #1;
        serve(2, 0, 1'b0, 3'b100);

        // Masters 0 and 1 together at rr=0
        mreq[0] = make_req(32'h4, 32'h0000_0011, 1'b1);
        mreq[1] = make_req(32'hC, 32'h0000_0033, 1'b1);
        #1;
        serve(0, 0, 1'b0, 3'b001);
        chk("t2_m1_waiting", 32'(mrsp[1].pready), 32'd0);
        serve(1, 0, 1'b0, 3'b010);

        // Slave waits 5 cycles and errors (moves rr 2 -> 0)
        mreq[2] = make_req(32'h10, 32'h0000_0044, 1'b0);
        #1;
        serve(2, 5, 1'b1, 3'b100);

        // All three continuously requesting
        mreq[0] = make_req(32'h20, 32'h0000_0100, 1'b1);
        mreq[1] = make_req(32'h24, 32'h0000_0101, 1'b1);
        mreq[2] = make_req(32'h28, 32'h0000_0102, 1'b1);
        #1;
        serve(0, 0, 1'b0, 3'b000);
        serve(1, 0, 1'b0, 3'b000);
        serve(2, 1, 1'b0, 3'b000);
        serve(0, 0, 1'b0, 3'b000);
        serve(1, 0, 1'b0, 3'b000);
        serve(2, 0, 1'b0, 3'b111);

        // Reset during ACCESS; master 0 first moves rr to 1
        mreq[0] = make_req(32'h30, 32'h0000_0200, 1'b1);
        #1;
        serve(0, 0, 1'b0, 3'b001);
        mreq[2] = make_req(32'h34, 32'h0000_0201, 1'b1);
        @(negedge clk);
        @(negedge clk); #1;
        chk("t5_in_access", 32'(sreq.penable), 32'd1);
        rst_n       = 1'b0;
        srsp.pready = 1'b1;
        #1;
        chk("t5_rst_psel", 32'(sreq.psel), 32'd0);
        chk("t5_rst_pready", 32'(mrsp[2].pready), 32'd0);
        chk("t5_rst_state", 32'(dut.state_q), 32'(IDLE));
        @(negedge clk);
        mreq[2] = '0;
        srsp    = '0;
        rst_n   = 1'b1;
        #1;
        chk("t5_rr_reset", 32'(dut.rr_q), 32'd0);
        @(negedge clk); #1;
        chk("t5_no_replay", 32'(dut.state_q), 32'(IDLE));

        // Granted master drops psel in SETUP; rr must stay at 1
        mreq[0] = make_req(32'h40, 32'h0000_0300, 1'b1);
        #1;
        serve(0, 0, 1'b0, 3'b001);
        mreq[2] = make_req(32'h44, 32'h0000_0301, 1'b1);
        @(negedge clk);
        mreq[2].psel = 1'b0;
        #1;
        chk("t6_setup_state", 32'(dut.state_q), 32'(SETUP));
        chk("t6_drop_psel", 32'(sreq.psel), 32'd0);
        @(negedge clk); #1;
        chk("t6_abort_idle", 32'(dut.state_q), 32'(IDLE));
        chk("t6_abort_psel", 32'(sreq.psel), 32'd0);
        chk("t6_rr_kept", 32'(dut.rr_q), 32'd1);
        @(negedge clk); #1;
        chk("t6_stays_idle", 32'(dut.state_q), 32'(IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
